esp32_boot_sequencer: RTL
=========================

// Module: esp32_boot_sequencer
// PURPOSE
//  Sequences ESP32 EN/GPIO0 for reset and boot-mode entry. Two requesters share these pins: the FTDI
//  DTR/RTS auto-reset and an internal FPGA requester (e.g. OSD/SPI loader). Owns the SD-line strap
//  drive (gpio 13,12,4,2) with its release timeout. Sits between the top-level pins and the serial passthru.
// PARAMETERS
//  C_reset_cycles          2500000  EN-low hold time of an internal sequence (100 ms @ 25 MHz)
//  C_strap_cycles          1250000  EN-high, GPIO0-held time after EN release (50 ms)
//  C_prog_release_timeout  26       SD strap release after 2^n cycles (2.6 s)
// PORTS
//  clk_25mhz    in   1  system clock
//  rstn         in   1  reset, synchronous, active-low
//  ftdi_ndtr    in   1  async; FTDI DTR, active-low
//  ftdi_nrts    in   1  async; FTDI RTS, active-low
//  btn_hold     in   1  sync; 1 = hold ESP32 in reset
//  req_valid    in   1  internal sequence request
//  req_boot     in   1  qualified by req_valid; 1 = download mode (GPIO0=0), 0 = normal run
//  req_ready    out  1  request accepted when req_valid & req_ready
//  busy         out  1  internal sequence in progress
//  done         out  1  one-cycle pulse, sequence completed
//  aborted      out  1  one-cycle pulse, sequence pre-empted
//  wifi_en      out  1  ESP32 EN
//  wifi_gpio0   out  1  ESP32 GPIO0
//  sd_oe        out  1  1 = drive sd_out onto sd_d, 0 = tri-state
//  sd_out       out  4  strap value {gpio13,gpio12,gpio4,gpio2}
// BEHAVIOUR
//  - ftdi_ndtr/ftdi_nrts: 2-FF synchronizers, reset to 2'b11. Map s={dtr,rts}: 10->{en,io0}=01,
//    01->10, else 11.
//  - FSM, reset state S_PASS:
//    S_PASS : en/io0 from FTDI map; req_ready=1 iff !btn_hold. Accept -> S_RST, latch req_boot,
//             cnt=0.
//    S_RST  : en=0, io0=~boot_l; cnt==C_reset_cycles-1 -> S_STRAP, cnt=0.
//    S_STRAP: en=1, io0=~boot_l; cnt==C_strap_cycles-1 -> S_DONE.
//    S_DONE : en=1, io0=1 (outputs in this state only); done=1 for 1 cycle -> S_PASS.
//  - busy=1 in S_RST/S_STRAP/S_DONE; req_ready=0 outside S_PASS.
//  - Pre-emption: in S_RST or S_STRAP, a synchronized FTDI transition into 10 or btn_hold=1
//    -> S_PASS next cycle, aborted=1 for 1 cycle, done not asserted. FTDI has priority.
//    Edge and terminal count in the same cycle: abort wins.
//  - btn_hold=1 forces wifi_en=0 in every state (combinational AND).
//  - Strap timer rel[C_prog_release_timeout:0], reset to MSB=1 with lower bits 0 (released).
//    Cleared to 0 on FTDI edge into 10, or on accepting a request with req_boot=1.
//    Increments while MSB=0, saturates at MSB=1.
//  - sd_oe=~rel[MSB]; sd_out={3'b101, wifi_gpio0 before btn_hold masking}.
//  - Reset values: state S_PASS, busy=0, done=0, aborted=0, sd_oe=0, wifi_en=1 (if !btn_hold),
//    wifi_gpio0=1, req_ready=1 (if !btn_hold).
//  - Reset mid-sequence: returns to S_PASS, no done/aborted pulse; timer forced to released.
//  - Counters: width $clog2(max(C_reset_cycles,C_strap_cycles)); no wrap (terminal compare).
//  - Latency: request accept -> en=0 on the next cycle. FTDI pin -> wifi_en is 2 cycles via sync.
// STRUCTURE
//  - Package esp32_boot_pkg: state enum (S_PASS,S_RST,S_STRAP,S_DONE), FTDI mapping function,
//    strap constant 3'b101.
//  - Sub-module esp32_prog_release_timer: strap release counter (clear, MSB output).
//  - Synchronizers inline.
// TESTING (C_reset_cycles=8, C_strap_cycles=4, C_prog_release_timeout=5)
//  - After reset, FTDI=11 -> en=1, io0=1, sd_oe=0, req_ready=1.
//  - FTDI=10 held -> 2 cycles later en=0, io0=1, sd_oe=1 for 32 cycles. FTDI=01 -> en=1, io0=0,
//    sd_out=4'b1010.
//  - req_valid with req_boot=1 -> en=0/io0=0 for 8 cycles, en=1/io0=0 for 4 cycles, done 1 cycle,
//    back to pass; sd_oe=1 for 32 cycles.
//  - req_boot=0 sequence -> io0=1 throughout, sd_oe stays 0, done pulses after 13 cycles.
//  - FTDI->10 at cycle 3 of S_RST -> aborted pulse, no done, en follows FTDI; same for btn_hold=1
//    (en=0).
//  - rstn=0 in S_STRAP -> next cycle S_PASS, busy=0, sd_oe=0, no pulses.

Source files
------------

// File: rtl/esp32_boot_pkg.sv
`default_nettype none
// ============================================================================
// esp32_boot_pkg : shared types and helpers for the ESP32 boot sequencer
// Revision 1.0 - initial release
// ============================================================================
package esp32_boot_pkg;

  typedef enum logic [1:0] {
    S_PASS  = 2'd0,
    S_RST   = 2'd1,
    S_STRAP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] STRAP_HI  = 3'b101;
  localparam logic [1:0] FTDI_BOOT = 2'b10;

  // {dtr,rts} (active-low pins, synchronized) -> {en,io0}
  function automatic logic [1:0] ftdi_map(input logic [1:0] s);
    logic [1:0] r;
    case (s)
      2'b10:   r = 2'b01;
      2'b01:   r = 2'b10;
      default: r = 2'b11;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/esp32_prog_release_timer.sv
`default_nettype none
// ============================================================================
// esp32_prog_release_timer : holds the SD strap drive for 2^TIMEOUT_LOG2 cycles
// Revision 1.0 - initial release
// ============================================================================
module esp32_prog_release_timer #(
  parameter int TIMEOUT_LOG2 = 26
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic released
);

  localparam int W = TIMEOUT_LOG2 + 1;

  logic [W-1:0] r_rel;

  // MSB set means released; counting stops once it reaches the MSB
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rel <= {1'b1, {TIMEOUT_LOG2{1'b0}}};
    end else if (clear) begin
      r_rel <= '0;
    end else if (!r_rel[W-1]) begin
      r_rel <= r_rel + W'(1);
    end
  end

  assign released = r_rel[W-1];

endmodule
`default_nettype wire

// File: rtl/esp32_boot_sequencer.sv
`default_nettype none
// ============================================================================
// esp32_boot_sequencer : arbitrates ESP32 EN/GPIO0 between FTDI auto-reset and
// an internal requester, and drives the SD-line boot straps.
// Revision 1.0 - initial release
// ============================================================================
module esp32_boot_sequencer
  import esp32_boot_pkg::*;
#(
  parameter int C_reset_cycles         = 2500000,
  parameter int C_strap_cycles         = 1250000,
  parameter int C_prog_release_timeout = 26
) (
  input  logic       clk_25mhz,
  input  logic       rstn,
  input  logic       ftdi_ndtr,
  input  logic       ftdi_nrts,
  input  logic       btn_hold,
  input  logic       req_valid,
  input  logic       req_boot,
  output logic       req_ready,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       wifi_en,
  output logic       wifi_gpio0,
  output logic       sd_oe,
  output logic [3:0] sd_out
);

  localparam int CNT_MAX = (C_reset_cycles > C_strap_cycles) ? C_reset_cycles : C_strap_cycles;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(C_reset_cycles - 1);
  localparam logic [CNT_W-1:0] STRAP_LAST = CNT_W'(C_strap_cycles - 1);

  logic [1:0]       r_dtr_sync;
  logic [1:0]       r_rts_sync;
  logic [1:0]       r_ftdi_prev;
  logic [1:0]       w_ftdi;
  logic [1:0]       w_map;
  logic             w_edge_boot;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_boot;
  logic             w_boot_next;
  logic             r_aborted;
  logic             w_abort;
  logic             w_accept;
  logic             w_en;
  logic             w_io0;
  logic             w_released;

  assign w_ftdi      = {r_dtr_sync[1], r_rts_sync[1]};
  assign w_map       = ftdi_map(w_ftdi);
  assign w_edge_boot = (w_ftdi == FTDI_BOOT) && (r_ftdi_prev != FTDI_BOOT);

  always_ff @(posedge clk_25mhz) begin
    if (!rstn) begin
      r_dtr_sync  <= 2'b11;
      r_rts_sync  <= 2'b11;
      r_ftdi_prev <= 2'b11;
      r_state     <= S_PASS;
      r_cnt       <= '0;
      r_boot      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_dtr_sync  <= {r_dtr_sync[0], ftdi_ndtr};
      r_rts_sync  <= {r_rts_sync[0], ftdi_nrts};
      r_ftdi_prev <= w_ftdi;
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_boot      <= w_boot_next;
      r_aborted   <= w_abort;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_boot_next  = r_boot;
    w_abort      = 1'b0;
    w_accept     = 1'b0;
    w_en         = 1'b1;
    w_io0        = 1'b1;
    req_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_PASS: begin
        busy          = 1'b0;
        {w_en, w_io0} = w_map;
        req_ready     = ~btn_hold;
        if (req_valid && !btn_hold) begin
          w_accept     = 1'b1;
          w_state_next = S_RST;
          w_boot_next  = req_boot;
          w_cnt_next   = '0;
        end
      end
      S_RST: begin
        w_en  = 1'b0;
        w_io0 = ~r_boot;
        // pre-emption outranks the terminal count
        if (w_edge_boot || btn_hold) begin
          w_abort      = 1'b1;
          w_state_next = S_PASS;
        end else if (r_cnt == RST_LAST) begin
          w_state_next = S_STRAP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_STRAP: begin
        w_io0 = ~r_boot;
        if (w_edge_boot || btn_hold) begin
          w_abort      = 1'b1;
          w_state_next = S_PASS;
        end else if (r_cnt == STRAP_LAST) begin
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_PASS;
      end
      default: begin
        w_state_next = S_PASS;
      end
    endcase
  end

  esp32_prog_release_timer #(
    .TIMEOUT_LOG2 (C_prog_release_timeout)
  ) u_release_timer (
    .clk      (clk_25mhz),
    .rstn     (rstn),
    .clear    (w_edge_boot || (w_accept && req_boot)),
    .released (w_released)
  );

  assign aborted    = r_aborted;
  assign wifi_en    = w_en & ~btn_hold;
  assign wifi_gpio0 = w_io0;
  assign sd_oe      = ~w_released;
  assign sd_out     = {STRAP_HI, w_io0};

endmodule
`default_nettype wire
